// File: rtl/width_down_conv.sv
// Wide-to-narrow serializer: one RATIO*OUT_W word in, RATIO OUT_W-bit lanes out, valid/ready on both sides.
// Optional idle fill on data_out is enabled with `define WIDTH_DOWN_CONV_IDLE_FILL_EN.
module width_down_conv #(
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
`ifdef WIDTH_DOWN_CONV_IDLE_FILL_EN
  ,
  parameter logic [OUT_W-1:0] IDLE_SYM = OUT_W'(8'hBC)
`endif
) (
  input  logic                   clk_4f,
  input  logic                   reset_L,
  input  logic [OUT_W*RATIO-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  output logic [OUT_W-1:0]       data_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [CNT_W-1:0]       word_cnt
);

  localparam int unsigned IN_W = OUT_W * RATIO;
  localparam int unsigned LW   = $clog2(RATIO);
  localparam logic [LW-1:0] LAST = LW'(RATIO - 1);
`ifdef WIDTH_DOWN_CONV_IDLE_FILL_EN
  localparam logic [OUT_W-1:0] IDLE_VAL = IDLE_SYM;
`else
  localparam logic [OUT_W-1:0] IDLE_VAL = '0;
`endif

  typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [IN_W-1:0]   hold;
  logic [LW-1:0]     lane;
  logic [LW-1:0]     nxt_lane;
  logic              last;
  logic              xfer;
  logic              accept;

  function automatic logic [OUT_W-1:0] lane_sel(input logic [IN_W-1:0] w, input logic [LW-1:0] n);
    logic [LW-1:0] idx;
    idx = MSB_FIRST ? (LAST - n) : n;
    return w[idx*OUT_W +: OUT_W];
  endfunction

  assign valid_out = (state == BUSY);
  assign last      = (lane == LAST);
  assign nxt_lane  = lane + LW'(1);
  assign xfer      = valid_out && ready_out;
  // A new word may enter in the same cycle the final lane leaves, so streams have no bubble.
  assign ready_in  = (state == EMPTY) || (xfer && last);
  assign accept    = valid_in && ready_in;

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      state    <= EMPTY;
      hold     <= '0;
      lane     <= '0;
      data_out <= IDLE_VAL;
      word_cnt <= '0;
    end else begin
      if (xfer && last) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (accept) begin
        hold     <= data_in;
        lane     <= '0;
        state    <= BUSY;
        data_out <= lane_sel(data_in, '0);
      end else if (xfer) begin
        if (last) begin
          state <= EMPTY;
          lane  <= '0;
`ifdef WIDTH_DOWN_CONV_IDLE_FILL_EN
          data_out <= IDLE_VAL;
`endif
        end else begin
          lane     <= nxt_lane;
          data_out <= lane_sel(hold, nxt_lane);
        end
      end
    end
  end

endmodule

// File: tb/tb_width_down_conv.sv
// Scoreboard bench for width_down_conv: stimulus pushes expected lanes, negedge monitors pop and compare.
// Three instances cover default, LSB-first nibble, and narrow-counter configurations.
module tb_width_down_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

`ifdef WIDTH_DOWN_CONV_IDLE_FILL_EN
  localparam logic [7:0] RST_D = 8'hBC;
`else
  localparam logic [7:0] RST_D = 8'h00;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // dut0: default parameters
  logic        rst0, v0_in, rdy0, v0_out, ro0;
  logic [31:0] d0_in;
  logic [7:0]  d0_out;
  logic [15:0] cnt0;
  logic [7:0]  q0[$];

  width_down_conv dut0 (
    .clk_4f(clk), .reset_L(rst0), .data_in(d0_in), .valid_in(v0_in), .ready_in(rdy0),
    .data_out(d0_out), .valid_out(v0_out), .ready_out(ro0), .word_cnt(cnt0)
  );

  // dut1: 4-bit lanes, 8 per word, least-significant first
  logic        rst_n, v1_in, rdy1, v1_out, ro1;
  logic [31:0] d1_in;
  logic [3:0]  d1_out;
  logic [15:0] cnt1;
  logic [3:0]  q1[$];

  width_down_conv #(.OUT_W(4), .RATIO(8), .MSB_FIRST(1'b0)) dut1 (
    .clk_4f(clk), .reset_L(rst_n), .data_in(d1_in), .valid_in(v1_in), .ready_in(rdy1),
    .data_out(d1_out), .valid_out(v1_out), .ready_out(ro1), .word_cnt(cnt1)
  );

  // dut2: 2-bit counter to exercise wrap
  logic        v2_in, rdy2, v2_out, ro2;
  logic [31:0] d2_in;
  logic [7:0]  d2_out;
  logic [1:0]  cnt2, prev_cnt2;
  logic [7:0]  q2[$];
  logic [1:0]  cq2[$];

  width_down_conv #(.CNT_W(2)) dut2 (
    .clk_4f(clk), .reset_L(rst_n), .data_in(d2_in), .valid_in(v2_in), .ready_in(rdy2),
    .data_out(d2_out), .valid_out(v2_out), .ready_out(ro2), .word_cnt(cnt2)
  );

  logic       held0_v = 1'b0;
  logic [7:0] held0_d;

  always @(negedge clk) begin
    if (held0_v) begin
      chk("hold0_valid", 64'(v0_out), 64'd1);
      chk("hold0_data", 64'(d0_out), 64'(held0_d));
    end
    if (v0_out === 1'b1 && ro0 === 1'b1) begin
      if (q0.size() == 0) chk("lane0_unexpected", 64'(d0_out), 64'hDEAD);
      else chk("lane0", 64'(d0_out), 64'(q0.pop_front()));
    end
    held0_v = (v0_out === 1'b1) && (ro0 === 1'b0) && (rst0 === 1'b1);
    held0_d = d0_out;
  end

  always @(negedge clk) begin
    if (v1_out === 1'b1 && ro1 === 1'b1) begin
      if (q1.size() == 0) chk("lane1_unexpected", 64'(d1_out), 64'hDEAD);
      else chk("lane1", 64'(d1_out), 64'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (v2_out === 1'b1 && ro2 === 1'b1) begin
      if (q2.size() == 0) chk("lane2_unexpected", 64'(d2_out), 64'hDEAD);
      else chk("lane2", 64'(d2_out), 64'(q2.pop_front()));
    end
    if (rst_n === 1'b1 && cnt2 !== prev_cnt2) begin
      if (cq2.size() == 0) chk("cnt2_unexpected", 64'(cnt2), 64'hDEAD);
      else chk("cnt2_seq", 64'(cnt2), 64'(cq2.pop_front()));
      prev_cnt2 = cnt2;
    end
  end

  task automatic push_word0(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) q0.push_back(8'(w >> (8 * i)));
  endtask

  // Offers w to dut0 until accepted; waited counts the cycles valid_in was held.
  task automatic send0(input logic [31:0] w, output int waited);
    logic r;
    r = 1'b0;
    waited = 0;
    d0_in = w;
    v0_in = 1'b1;
    while (!r && waited < 64) begin
      @(negedge clk);
      r = rdy0;
      @(posedge clk);
      #1;
      waited++;
    end
    v0_in = 1'b0;
    if (!r) chk("send0_timeout", 64'(waited), 64'd0);
  endtask

  task automatic drain0(input string name);
    for (int i = 0; i < 64 && q0.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 64'(q0.size()), 64'd0);
  endtask

  logic [9:0] pat;
  int n, n2;
  logic [31:0] w2;

  initial begin
    rst0 = 1'b0; rst_n = 1'b0;
    v0_in = 1'b0; d0_in = '0; ro0 = 1'b1;
    v1_in = 1'b0; d1_in = '0; ro1 = 1'b1;
    v2_in = 1'b0; d2_in = '0; ro2 = 1'b1;
    prev_cnt2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(v0_out), 64'd0);
    chk("rst_data", 64'(d0_out), 64'(RST_D));
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    rst0 = 1'b1; rst_n = 1'b1;

    // Single word, valid pulsed one cycle
    push_word0(32'hFFFBBFFF);
    send0(32'hFFFBBFFF, n);
    chk("t1_wait", 64'(n), 64'd1);
    drain0("t1_drain");
    chk("t1_valid_low", 64'(v0_out), 64'd0);
    chk("t1_cnt", 64'(cnt0), 64'd1);
`ifdef WIDTH_DOWN_CONV_IDLE_FILL_EN
    chk("t1_idle_data", 64'(d0_out), 64'hBC);
`else
    chk("t1_idle_data", 64'(d0_out), 64'hFF);
`endif

    // Back-to-back words, no bubble
    push_word0(32'hDDDDDDDD);
    push_word0(32'hDD000003);
    send0(32'hDDDDDDDD, n);
    chk("t2_wait_first", 64'(n), 64'd1);
    fork
      send0(32'hDD000003, n2);
      begin
        int c;
        c = 0;
        repeat (8) begin
          @(negedge clk);
          if (v0_out === 1'b1) c++;
        end
        chk("t2_continuous", 64'(c), 64'd8);
      end
    join
    chk("t2_wait_second", 64'(n2), 64'd4);
    drain0("t2_drain");
    chk("t2_cnt", 64'(cnt0), 64'd3);

    // Backpressure 1,0,0,1,... with the next word waiting
    push_word0(32'h01020304);
    push_word0(32'h0A0B0C0D);
    send0(32'h01020304, n);
    pat = 10'b1001001001;
    fork
      begin
        for (int p = 0; p < 10; p++) begin
          ro0 = pat[p];
          @(posedge clk);
          #1;
        end
        ro0 = 1'b1;
      end
      send0(32'h0A0B0C0D, n2);
    join
    chk("t3_wait_accept", 64'(n2), 64'd10);
    drain0("t3_drain");
    chk("t3_cnt", 64'(cnt0), 64'd5);

    // Reset mid-word, then a clean word
    q0.push_back(8'hAA);
    q0.push_back(8'hBB);
    send0(32'hAABBCCDD, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ro0 = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;
    chk("t5_valid", 64'(v0_out), 64'd0);
    chk("t5_data", 64'(d0_out), 64'(RST_D));
    chk("t5_cnt", 64'(cnt0), 64'd0);
    chk("t5_q", 64'(q0.size()), 64'd0);
    rst0 = 1'b1; ro0 = 1'b1;
    push_word0(32'h11223344);
    send0(32'h11223344, n);
    drain0("t5_drain");
    chk("t5_cnt_after", 64'(cnt0), 64'd1);

    // LSB-first nibbles
    for (int i = 0; i < 8; i++) q1.push_back(4'(8 - i));
    chk("t4_ready", 64'(rdy1), 64'd1);
    d1_in = 32'h12345678;
    v1_in = 1'b1;
    @(posedge clk); #1;
    v1_in = 1'b0;
    for (int i = 0; i < 64 && q1.size() != 0; i++) @(posedge clk);
    #1;
    chk("t4_drain", 64'(q1.size()), 64'd0);
    chk("t4_valid_low", 64'(v1_out), 64'd0);
    chk("t4_cnt", 64'(cnt1), 64'd1);

    // Counter wrap with CNT_W=2, five words streamed
    cq2.push_back(2'd1); cq2.push_back(2'd2); cq2.push_back(2'd3);
    cq2.push_back(2'd0); cq2.push_back(2'd1);
    v2_in = 1'b1;
    for (int w = 0; w < 5; w++) begin
      logic r;
      r = 1'b0;
      w2 = 32'h00112233 + 32'(w) * 32'h44444444;
      for (int i = 3; i >= 0; i--) q2.push_back(8'(w2 >> (8 * i)));
      d2_in = w2;
      for (int k = 0; k < 16 && !r; k++) begin
        @(negedge clk);
        r = rdy2;
        @(posedge clk);
        #1;
      end
      if (!r) chk("t6_timeout", 64'(w), 64'hFFFF);
    end
    v2_in = 1'b0;
    for (int i = 0; i < 64 && (q2.size() != 0 || cq2.size() != 0); i++) @(posedge clk);
    @(posedge clk); #1;
    chk("t6_drain", 64'(q2.size()), 64'd0);
    chk("t6_cnt_seq_done", 64'(cq2.size()), 64'd0);
    chk("t6_cnt", 64'(cnt2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
